// File: rtl/step_motor_homing_ctrl_if.sv
// step_motor_homing_ctrl_if: control/status bundle between the homing controller and one motor channel
// master: drives m_start, m_stop, m_dir, m_speed, m_step, m_ms; samples m_state (running), m_zpsign (zero sensor)
// slave:  motor channel side of the same signals
interface step_motor_homing_ctrl_if #(
  parameter int C_STEP_NUMBER_WIDTH = 16,
  parameter int C_SPEED_DATA_WIDTH  = 16,
  parameter int C_MICROSTEP_WIDTH   = 3
);
  logic                           m_start;
  logic                           m_stop;
  logic                           m_dir;
  logic [C_SPEED_DATA_WIDTH-1:0]  m_speed;
  logic [C_STEP_NUMBER_WIDTH-1:0] m_step;
  logic [C_MICROSTEP_WIDTH-1:0]   m_ms;
  logic                           m_state;
  logic                           m_zpsign;
  modport master(output m_start, m_stop, m_dir, m_speed, m_step, m_ms, input m_state, m_zpsign);
  modport slave(input m_start, m_stop, m_dir, m_speed, m_step, m_ms, output m_state, m_zpsign);
endinterface

// File: rtl/step_motor_homing_ctrl.sv
// step_motor_homing_ctrl: seek / back-off / fine re-approach homing sequencer for one step-motor channel
// clk, resetn (async active-low); cmd_home / cmd_abort: single-cycle host pulses
// cfg_*: seek/fine speed, max seek travel, back-off travel, microstep select (latched on start)
// busy, done_pulse, home_ok, home_err: host status; m: motor channel bundle (master side)
module step_motor_homing_ctrl #(
  parameter int   C_STEP_NUMBER_WIDTH = 16,
  parameter int   C_SPEED_DATA_WIDTH  = 16,
  parameter int   C_MICROSTEP_WIDTH   = 3,
  parameter logic C_HOME_DIR          = 1'b0,
  parameter int   C_REQ_TIMEOUT       = 64
)(
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           cmd_home,
  input  logic                           cmd_abort,
  input  logic [C_SPEED_DATA_WIDTH-1:0]  cfg_seek_speed,
  input  logic [C_SPEED_DATA_WIDTH-1:0]  cfg_fine_speed,
  input  logic [C_STEP_NUMBER_WIDTH-1:0] cfg_max_steps,
  input  logic [C_STEP_NUMBER_WIDTH-1:0] cfg_backoff_steps,
  input  logic [C_MICROSTEP_WIDTH-1:0]   cfg_ms,
  output logic                           busy,
  output logic                           done_pulse,
  output logic                           home_ok,
  output logic [2:0]                     home_err,
  step_motor_homing_ctrl_if.master       m
);
  localparam int SN = C_STEP_NUMBER_WIDTH;
  localparam int SD = C_SPEED_DATA_WIDTH;
  localparam logic [15:0] L_TO_LAST = 16'(C_REQ_TIMEOUT - 1);
  typedef enum logic [3:0] {IDLE, SEEK_REQ, SEEK_RUN, HALT, BACK_REQ, BACK_RUN, FINE_REQ, FINE_RUN, DONE, ERR} state_t;
  state_t r_state, w_nxt, r_ret, w_ret;
  logic [2:0] r_err, w_err;
  logic [15:0] r_cnt;
  logic [SD-1:0] r_seek_speed, r_fine_speed, w_seek_speed, w_fine_speed;
  logic [SN-1:0] r_max, r_back, w_max, w_back, w_fine_step;
  logic [SN:0] w_dbl;
  logic w_idle, w_accept, w_abort;
  assign w_idle       = r_state inside {IDLE, DONE, ERR};
  assign w_accept     = cmd_home && w_idle;
  assign w_abort      = cmd_abort && !w_idle;
  // the first request is issued on the accept edge, before the latches hold the new config
  assign w_seek_speed = w_accept ? cfg_seek_speed : r_seek_speed;
  assign w_fine_speed = w_accept ? cfg_fine_speed : r_fine_speed;
  assign w_max        = w_accept ? cfg_max_steps : r_max;
  assign w_back       = w_accept ? cfg_backoff_steps : r_back;
  assign w_dbl        = {w_back, 1'b0};
  assign w_fine_step  = w_dbl[SN] ? '1 : w_dbl[SN-1:0];
  always_comb begin
    w_nxt = r_state;
    w_ret = r_ret;
    w_err = r_err;
    case (r_state)
      IDLE, DONE, ERR: begin
        w_nxt = w_accept ? (m.m_zpsign ? BACK_REQ : SEEK_REQ) : IDLE;
        w_err = w_accept ? 3'd0 : r_err;
      end
      SEEK_REQ, BACK_REQ, FINE_REQ: begin
        if (m.m_state) w_nxt = r_state == SEEK_REQ ? SEEK_RUN : r_state == BACK_REQ ? BACK_RUN : FINE_RUN;
        else if (r_cnt == L_TO_LAST) begin
          w_nxt = ERR;
          w_err = 3'd5;
        end
      end
      SEEK_RUN: begin
        if (m.m_zpsign) begin
          w_nxt = HALT;
          w_ret = BACK_REQ;
        end else if (!m.m_state) begin
          w_nxt = ERR;
          w_err = 3'd1;
        end
      end
      BACK_RUN: begin
        if (!m.m_state) begin
          w_nxt = m.m_zpsign ? ERR : FINE_REQ;
          w_err = m.m_zpsign ? 3'd2 : r_err;
        end
      end
      FINE_RUN: begin
        if (m.m_zpsign) begin
          w_nxt = HALT;
          w_ret = DONE;
        end else if (!m.m_state) begin
          w_nxt = ERR;
          w_err = 3'd3;
        end
      end
      HALT: w_nxt = m.m_state ? HALT : r_ret;
      default: w_nxt = IDLE;
    endcase
    // abort beats any sensor event this cycle; a pending halt error keeps its code
    if (w_abort) begin
      w_nxt = m.m_state ? HALT : ERR;
      w_ret = ERR;
      w_err = r_err != 3'd0 ? r_err : 3'd4;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_ret        <= IDLE;
      r_err        <= '0;
      r_cnt        <= '0;
      r_seek_speed <= '0;
      r_fine_speed <= '0;
      r_max        <= '0;
      r_back       <= '0;
      busy         <= 1'b0;
      done_pulse   <= 1'b0;
      home_ok      <= 1'b0;
      home_err     <= '0;
      m.m_start    <= 1'b0;
      m.m_stop     <= 1'b0;
      m.m_dir      <= 1'b0;
      m.m_speed    <= '0;
      m.m_step     <= '0;
      m.m_ms       <= '0;
    end else begin
      r_state      <= w_nxt;
      r_ret        <= w_ret;
      r_err        <= w_err;
      r_cnt        <= w_nxt != r_state ? 16'd0 : r_cnt + 16'd1;
      r_seek_speed <= w_seek_speed;
      r_fine_speed <= w_fine_speed;
      r_max        <= w_max;
      r_back       <= w_back;
      m.m_ms       <= w_accept ? cfg_ms : m.m_ms;
      busy         <= !(w_nxt inside {IDLE, DONE, ERR});
      done_pulse   <= w_nxt inside {DONE, ERR};
      home_ok      <= w_nxt == DONE || (home_ok && !w_accept);
      home_err     <= w_nxt == ERR ? w_err : w_accept ? 3'd0 : home_err;
      m.m_start    <= w_nxt inside {SEEK_REQ, BACK_REQ, FINE_REQ};
      m.m_stop     <= w_nxt == HALT;
      m.m_dir      <= w_nxt inside {SEEK_REQ, FINE_REQ} ? C_HOME_DIR : w_nxt == BACK_REQ ? ~C_HOME_DIR : m.m_dir;
      m.m_speed    <= w_nxt == SEEK_REQ ? w_seek_speed : w_nxt inside {BACK_REQ, FINE_REQ} ? w_fine_speed : m.m_speed;
      m.m_step     <= w_nxt == SEEK_REQ ? w_max : w_nxt == BACK_REQ ? w_back : w_nxt == FINE_REQ ? w_fine_step : m.m_step;
    end
  end
endmodule

// File: tb/tb_step_motor_homing_ctrl.sv
// tb_step_motor_homing_ctrl: directed self-checking bench with a simple stepping motor model
`timescale 1ns/1ps
module tb_step_motor_homing_ctrl;
  localparam logic HD = 1'b0;
  logic clk = 1'b0, resetn = 1'b0, cmd_home = 1'b0, cmd_abort = 1'b0;
  logic [15:0] cfg_seek_speed = 16'h0100, cfg_fine_speed = 16'h0010;
  logic [15:0] cfg_max_steps = 16'd1000, cfg_backoff_steps = 16'd40;
  logic [2:0] cfg_ms = 3'd5;
  logic busy, done_pulse, home_ok;
  logic [2:0] home_err;
  logic auto_mode = 1'b0, stuck = 1'b0, man_state = 1'b0, man_zps = 1'b0;
  int pos0 = 500, pos = 0, dly = 0, left = 0;
  logic run = 1'b0, mdir = 1'b0;
  int n_chk = 0, n_fail = 0;
  logic q_dir[$];
  logic [15:0] q_step[$], q_speed[$];
  int n_done = 0, n_halt = 0;
  logic prev_start = 1'b0, prev_stop = 1'b0, prev_busy = 1'b0, busy_before_done = 1'b0;
  step_motor_homing_ctrl_if #(.C_STEP_NUMBER_WIDTH(16), .C_SPEED_DATA_WIDTH(16), .C_MICROSTEP_WIDTH(3)) mi();
  step_motor_homing_ctrl #(.C_HOME_DIR(HD), .C_REQ_TIMEOUT(64)) dut (
    .clk(clk), .resetn(resetn), .cmd_home(cmd_home), .cmd_abort(cmd_abort),
    .cfg_seek_speed(cfg_seek_speed), .cfg_fine_speed(cfg_fine_speed),
    .cfg_max_steps(cfg_max_steps), .cfg_backoff_steps(cfg_backoff_steps), .cfg_ms(cfg_ms),
    .busy(busy), .done_pulse(done_pulse), .home_ok(home_ok), .home_err(home_err), .m(mi.master)
  );
  always #5 clk = ~clk;
  assign mi.m_state  = auto_mode ? run : man_state;
  assign mi.m_zpsign = auto_mode ? (stuck || pos <= 0) : man_zps;
  always @(posedge clk) begin
    if (!auto_mode) begin
      run <= 1'b0;
      dly <= 0;
      pos <= pos0;
    end else if (!run) begin
      dly <= mi.m_start ? dly + 1 : 0;
      if (mi.m_start && dly == 2) begin
        run  <= 1'b1;
        left <= int'(mi.m_step);
        mdir <= mi.m_dir;
      end
    end else if (mi.m_stop || left == 0) run <= 1'b0;
    else begin
      pos  <= mdir == HD ? pos - 1 : pos + 1;
      left <= left - 1;
    end
  end
  always @(negedge clk) begin
    if (mi.m_start && !prev_start) begin
      q_dir.push_back(mi.m_dir);
      q_step.push_back(mi.m_step);
      q_speed.push_back(mi.m_speed);
    end
    if (mi.m_stop && !prev_stop) n_halt++;
    if (done_pulse) begin
      n_done++;
      busy_before_done = prev_busy;
    end
    prev_start = mi.m_start;
    prev_stop  = mi.m_stop;
    prev_busy  = busy;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic home();
    cmd_home = 1'b1;
    @(negedge clk);
    cmd_home = 1'b0;
  endtask
  task automatic abort();
    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int bound);
    int k = 0;
    while (!done_pulse && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk(tag, done_pulse, 1);
  endtask
  initial begin
    int base, bd, bh, n, k;
    cyc(2);
    chk("rst_busy", busy, 0);
    chk("rst_done", done_pulse, 0);
    chk("rst_ok", home_ok, 0);
    chk("rst_err", home_err, 0);
    chk("rst_start", mi.m_start, 0);
    chk("rst_stop", mi.m_stop, 0);
    chk("rst_step", mi.m_step, 0);
    chk("rst_ms", mi.m_ms, 0);
    resetn = 1'b1;
    cyc(2);
    pos0 = 500;
    cyc(1);
    base = q_dir.size(); bd = n_done; bh = n_halt;
    auto_mode = 1'b1;
    home();
    chk("nom_busy", busy, 1);
    chk("nom_start", mi.m_start, 1);
    chk("nom_dir", mi.m_dir, 0);
    chk("nom_step", mi.m_step, 1000);
    chk("nom_speed", mi.m_speed, 16'h0100);
    chk("nom_ms", mi.m_ms, 5);
    wait_done("nom_done_seen", 5000);
    chk("nom_ok", home_ok, 1);
    chk("nom_err", home_err, 0);
    chk("nom_busy_end", busy, 0);
    cyc(3);
    chk("nom_pulses", n_done - bd, 1);
    chk("nom_halts", n_halt - bh, 2);
    chk("nom_reqs", q_dir.size() - base, 3);
    chk("nom_back_dir", q_dir[base+1], 1);
    chk("nom_back_step", q_step[base+1], 40);
    chk("nom_back_speed", q_speed[base+1], 16'h0010);
    chk("nom_fine_dir", q_dir[base+2], 0);
    chk("nom_fine_step", q_step[base+2], 80);
    chk("nom_fine_speed", q_speed[base+2], 16'h0010);
    auto_mode = 1'b0;
    cfg_max_steps = 16'd200;
    pos0 = 100000;
    cyc(2);
    base = q_dir.size(); bd = n_done;
    auto_mode = 1'b1;
    home();
    wait_done("abs_done_seen", 1000);
    chk("abs_err", home_err, 1);
    chk("abs_ok", home_ok, 0);
    chk("abs_busy", busy, 0);
    cyc(2);
    chk("abs_busy_before", busy_before_done, 1);
    chk("abs_pulses", n_done - bd, 1);
    chk("abs_reqs", q_dir.size() - base, 1);
    auto_mode = 1'b0;
    cfg_max_steps = 16'd1000;
    pos0 = 0;
    cyc(2);
    auto_mode = 1'b1;
    home();
    chk("on_dir", mi.m_dir, 1);
    chk("on_step", mi.m_step, 40);
    chk("on_speed", mi.m_speed, 16'h0010);
    wait_done("on_done_seen", 2000);
    chk("on_ok", home_ok, 1);
    auto_mode = 1'b0;
    cyc(2);
    cfg_backoff_steps = 16'hFFF0;
    man_zps = 1'b1;
    home();
    chk("sat_back_step", mi.m_step, 16'hFFF0);
    chk("sat_back_dir", mi.m_dir, 1);
    man_state = 1'b1;
    @(negedge clk);
    chk("sat_start_drop", mi.m_start, 0);
    man_state = 1'b0;
    man_zps = 1'b0;
    @(negedge clk);
    chk("sat_fine_start", mi.m_start, 1);
    chk("sat_fine_step", mi.m_step, 16'hFFFF);
    chk("sat_fine_dir", mi.m_dir, 0);
    abort();
    chk("sat_abort_err", home_err, 4);
    chk("sat_abort_pulse", done_pulse, 1);
    man_zps = 1'b1;
    home();
    man_state = 1'b1;
    @(negedge clk);
    man_state = 1'b0;
    @(negedge clk);
    chk("e2_err", home_err, 2);
    chk("e2_pulse", done_pulse, 1);
    chk("e2_busy", busy, 0);
    man_zps = 1'b0;
    cfg_backoff_steps = 16'd40;
    cyc(2);
    home();
    man_state = 1'b1;
    @(negedge clk);
    chk("ab_start_drop", mi.m_start, 0);
    abort();
    chk("ab_stop", mi.m_stop, 1);
    chk("ab_start_excl", mi.m_start, 0);
    @(negedge clk);
    chk("ab_stop_held", mi.m_stop, 1);
    chk("ab_busy_held", busy, 1);
    man_state = 1'b0;
    @(negedge clk);
    chk("ab_stop_rel", mi.m_stop, 0);
    chk("ab_err", home_err, 4);
    chk("ab_pulse", done_pulse, 1);
    chk("ab_busy", busy, 0);
    @(negedge clk);
    chk("ab_pulse_once", done_pulse, 0);
    chk("ab_err_hold", home_err, 4);
    home();
    man_state = 1'b1;
    @(negedge clk);
    man_zps = 1'b1;
    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
    chk("abz_stop", mi.m_stop, 1);
    man_state = 1'b0;
    @(negedge clk);
    chk("abz_err", home_err, 4);
    chk("abz_no_back", mi.m_start, 0);
    chk("abz_ok", home_ok, 0);
    man_zps = 1'b0;
    cyc(2);
    home();
    n = 0; k = 0;
    while (busy && k < 200) begin
      if (mi.m_start) n++;
      k++;
      @(negedge clk);
    end
    chk("to_start_cycles", n, 64);
    chk("to_err", home_err, 5);
    chk("to_pulse", done_pulse, 1);
    cyc(2);
    home();
    cyc(3);
    chk("rs_pre_start", mi.m_start, 1);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("rs_busy", busy, 0);
    chk("rs_start", mi.m_start, 0);
    chk("rs_speed", mi.m_speed, 0);
    chk("rs_step", mi.m_step, 0);
    chk("rs_ms", mi.m_ms, 0);
    chk("rs_err", home_err, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    home();
    chk("rs_again_start", mi.m_start, 1);
    chk("rs_again_busy", busy, 1);
    abort();
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/step_motor_homing_ctrl.md
# step_motor_homing_ctrl

Sequences one step-motor channel through a zero-position homing cycle: a fast seek toward the zero sensor, a back-off, and a slow fine re-approach. It sits between the host register bank and one `s<i>_*` control/status group of the multi-motor step-motor core. It drives start/stop/dir/speed/step/ms and watches the channel's state and zpsign. It reports completion or a coded failure.

## Interface
- `C_STEP_NUMBER_WIDTH`, 16, width of step counts.
- `C_SPEED_DATA_WIDTH`, 16, width of speed words.
- `C_MICROSTEP_WIDTH`, 3, width of microstep select.
- `C_HOME_DIR`, 0, dir value that moves toward the zero sensor.
- `C_REQ_TIMEOUT`, 64, cycles allowed for `m_state` to rise after start (range 2..65535).
- `clk`  in  1  clock.
- `resetn`  in  1  asynchronous active-low reset.
- `cmd_home`  in  1  single-cycle pulse, begin homing.
- `cmd_abort`  in  1  single-cycle pulse, abort homing.
- `cfg_seek_speed`  in  C_SPEED_DATA_WIDTH  speed word for the seek phase.
- `cfg_fine_speed`  in  C_SPEED_DATA_WIDTH  speed word for the back-off and fine phases.
- `cfg_max_steps`  in  C_STEP_NUMBER_WIDTH  maximum seek travel.
- `cfg_backoff_steps`  in  C_STEP_NUMBER_WIDTH  back-off travel.
- `cfg_ms`  in  C_MICROSTEP_WIDTH  microstep setting, passed through.
- `busy`  out  1  homing in progress.
- `done_pulse`  out  1  one-cycle pulse on the DONE or ERR entry.
- `home_ok`  out  1  last cycle succeeded; level.
- `home_err`  out  3  error code of the last cycle; 0 means none.
- `m_start`  out  1  start request to the motor channel.
- `m_stop`  out  1  stop request to the motor channel.
- `m_dir`  out  1  motion direction.
- `m_speed`  out  C_SPEED_DATA_WIDTH  speed word.
- `m_step`  out  C_STEP_NUMBER_WIDTH  step count.
- `m_ms`  out  C_MICROSTEP_WIDTH  microstep select.
- `m_state`  in  1  channel running.
- `m_zpsign`  in  1  zero sensor asserted, same clock domain.

## Operation
- All outputs are registered. Reset value is 0 for every output; `m_ms` resets to 0.
- FSM states: IDLE, SEEK_REQ, SEEK_RUN, HALT, BACK_REQ, BACK_RUN, FINE_REQ, FINE_RUN, DONE, ERR.
- **Start.** `cmd_home` is accepted in IDLE, DONE or ERR and ignored otherwise. On acceptance, `cfg_*` values are latched, `home_ok` and `home_err` clear, and `busy` is set.
  - If `m_zpsign`=1 at acceptance: skip the seek and go to BACK_REQ.
  - Otherwise go to SEEK_REQ.
- **Request states (SEEK/BACK/FINE_REQ).**
  - `m_start` is held at 1 until `m_state`=1 is sampled; the state then advances to the matching RUN state and `m_start` drops.
  - A per-request counter times out after C_REQ_TIMEOUT cycles: error 5.
  - Motion settings per request state:
    - SEEK_REQ: dir = C_HOME_DIR, speed = seek, step = max.
    - BACK_REQ: dir = ~C_HOME_DIR, speed = fine, step = backoff.
    - FINE_REQ: dir = C_HOME_DIR, speed = fine, step = min(2·backoff, all-ones), saturating and computed one bit wider.
- **SEEK_RUN.**
  - `m_zpsign`=1: go to HALT, with BACK_REQ as the next state.
  - `m_state` falls with `m_zpsign`=0: error 1, sensor not found.
- **BACK_RUN.**
  - `m_state` falls with `m_zpsign`=0: go to FINE_REQ.
  - `m_state` falls with `m_zpsign`=1: error 2, back-off did not clear the sensor.
- **FINE_RUN.**
  - `m_zpsign`=1: go to HALT, with DONE as the next state.
  - `m_state` falls with `m_zpsign`=0: error 3.
- **HALT.** `m_stop` is held at 1 until `m_state`=0 is sampled, then control goes to the stored next state.
- **Abort.** `cmd_abort` in any busy state:
  - If `m_state`=1: enter HALT with ERR as the next state.
  - Otherwise: go to ERR directly.
  - Error code 4. Abort overrides a `m_zpsign` event sampled in the same cycle.
- **Error precedence.** The first error recorded wins; abort during a HALT that already has a pending error keeps the earlier code.
- **DONE.** Sets `home_ok`, pulses `done_pulse`, clears `busy`, and returns to IDLE on the next cycle.
- **ERR.** Sets `home_err`, pulses `done_pulse`, clears `busy`, and returns to IDLE; `home_err` is held.
- `m_stop` and `m_start` are never 1 in the same cycle.

## Timing
- `cmd_home` sampled in cycle N: `busy`=1, the request-state `m_dir`/`m_speed`/`m_step` values and `m_start`=1 all appear at N+1.
- `m_state`=1 sampled at cycle K in a REQ state: `m_start`=0 at K+1.
- `m_zpsign`=1 sampled at cycle Z in SEEK_RUN/FINE_RUN: `m_stop`=1 at Z+1.
- `m_state`=0 sampled at cycle H in HALT: `m_stop`=0 at H+1. The next REQ state drives `m_start`=1 at H+1, or DONE/ERR takes effect at H+1.
- `done_pulse`, and the `home_ok`/`home_err` update, land on the same cycle as `busy` falling.
- Asynchronous reset mid-cycle clears every output immediately and returns the FSM to IDLE. No stop is issued; the motor core shares the same reset.

## Test plan
- **Nominal homing.** Motor model with state rising 3 cycles after start, sensor at step 500, max=1000, backoff=40 → sequence SEEK→HALT→BACK(40)→FINE(step=80)→HALT→DONE; `home_ok`=1, `home_err`=0, one `done_pulse`.
- **Sensor absent.** max=200, sensor never asserts → seek ends, `home_err`=1, `home_ok`=0, `busy` falls with `done_pulse`.
- **Already on sensor.** `m_zpsign`=1 at `cmd_home` → first request is BACK_REQ with `m_dir`=~C_HOME_DIR and `m_step`=backoff.
- **Back-off saturation and error 2.** backoff=16'hFFF0, sensor stuck at 1 → fine step is 16'hFFFF if reached; a stuck sensor gives `home_err`=2 after BACK_RUN.
- **Abort during seek run.** → `m_stop` held until `m_state`=0, `home_err`=4. Abort in the same cycle as `m_zpsign` rising → still error 4.
- **Timeout and reset mid-seek.** `m_state` never rises → `m_start` is held for 64 cycles, then `home_err`=5. A `resetn` pulse mid-seek → all outputs 0 immediately and a fresh `cmd_home` is accepted.
